// File: rtl/fifo_drain_arb.sv
// Round-robin drain arbiter for several FIFO read ports.
// Each grant pops up to 2**BURSTBITS words from one channel into a single registered
// valid/ready output stream. The FIFO underflow flags are collected into a sticky error.
module fifo_drain_arb #(
  parameter int unsigned NCHAN     = 4,
  parameter int unsigned CHANBITS  = 2,
  parameter int unsigned DATAWIDTH = 18,
  parameter int unsigned BURSTBITS = 3
) (
  input  logic                       clk,
  input  logic                       reset_l,
  input  logic                       enable,
  input  logic [NCHAN-1:0]           fifo_ne,
  input  logic [NCHAN*DATAWIDTH-1:0] fifo_rd_data,
  input  logic [NCHAN-1:0]           fifo_unf,
  output logic [NCHAN-1:0]           fifo_re,
  output logic [DATAWIDTH-1:0]       out_data,
  output logic [CHANBITS-1:0]        out_chan,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       err
);

  localparam int unsigned CntW = BURSTBITS + 1;
  localparam logic [CntW-1:0] BurstLen = CntW'(1) << BURSTBITS;

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e               state_q, state_d;
  logic [CHANBITS-1:0]  ptr_q, ptr_d;
  logic [CHANBITS-1:0]  grant_q, grant_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [DATAWIDTH-1:0] data_q;
  logic [CHANBITS-1:0]  chan_q;
  logic                 valid_q;
  logic                 err_q;

  logic [CHANBITS-1:0]  sel;
  logic                 found;
  logic [CHANBITS-1:0]  grant_next;
  logic                 ne_g;
  logic [DATAWIDTH-1:0] head;
  logic                 can_load;
  logic                 pop;

  // Pick the first non-empty channel at or above ptr, then wrap around to the bottom.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int unsigned i = 0; i < NCHAN; i++) begin
      if (!found && fifo_ne[i] && (CHANBITS'(i) >= ptr_q)) begin
        found = 1'b1;
        sel   = CHANBITS'(i);
      end
    end
    for (int unsigned i = 0; i < NCHAN; i++) begin
      if (!found && fifo_ne[i]) begin
        found = 1'b1;
        sel   = CHANBITS'(i);
      end
    end
  end

  // Select the not-empty flag and the head word of the granted channel.
  always_comb begin
    ne_g = 1'b0;
    head = '0;
    for (int unsigned i = 0; i < NCHAN; i++) begin
      if (grant_q == CHANBITS'(i)) begin
        ne_g = fifo_ne[i];
        head = fifo_rd_data[i*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

  // Shared pop qualifiers. Popping is allowed only when the output slot is free or is
  // draining in this same cycle.
  always_comb begin
    grant_next = (grant_q == CHANBITS'(NCHAN - 1)) ? '0 : grant_q + CHANBITS'(1);
    can_load   = !valid_q || out_ready;
    pop        = (state_q == StBurst) && ne_g && can_load;
  end

  // State register: arbitration state, pointer, grant and burst count.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      grant_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      count_q <= count_d;
    end
  end

  // Next-state logic. A burst ends on the BurstLen-th pop or when the granted FIFO runs dry.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        if (enable && found) begin
          grant_d = sel;
          count_d = '0;
          state_d = StBurst;
        end
      end
      StBurst: begin
        if (!ne_g) begin
          state_d = StIdle;
          ptr_d   = grant_next;
        end else if (pop) begin
          count_d = count_q + CntW'(1);
          if (count_q + CntW'(1) == BurstLen) begin
            state_d = StIdle;
            ptr_d   = grant_next;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode. The pop strobe is one-hot on the granted channel.
  always_comb begin
    fifo_re = '0;
    for (int unsigned i = 0; i < NCHAN; i++) begin
      if (pop && (grant_q == CHANBITS'(i))) fifo_re[i] = 1'b1;
    end
    busy = (state_q == StBurst);
  end

  // Output register. A pop reloads it, and an accept without a pop empties it.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
    end else if (pop) begin
      data_q  <= head;
      chan_q  <= grant_q;
      valid_q <= 1'b1;
    end else if (valid_q && out_ready) begin
      valid_q <= 1'b0;
    end
  end

  // Sticky underflow error. Only reset clears it.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      err_q <= 1'b0;
    end else if (|fifo_unf) begin
      err_q <= 1'b1;
    end
  end

  assign out_data  = data_q;
  assign out_chan  = chan_q;
  assign out_valid = valid_q;
  assign err       = err_q;

endmodule

// File: tb/tb_fifo_drain_arb.sv
// Directed bench for fifo_drain_arb. A queue model per channel stands in for the
// FIFOs, and the bench acts as an always-present consumer that logs accepted words.
module tb_fifo_drain_arb;

  localparam int NCHAN = 4;
  localparam int CB    = 2;
  localparam int DW    = 18;
  localparam int BB    = 3;

  logic                clk = 1'b0;
  logic                reset_l;
  logic                enable;
  logic [NCHAN-1:0]    fifo_ne;
  logic [NCHAN*DW-1:0] fifo_rd_data;
  logic [NCHAN-1:0]    fifo_unf;
  logic [NCHAN-1:0]    fifo_re;
  logic [DW-1:0]       out_data;
  logic [CB-1:0]       out_chan;
  logic                out_valid;
  logic                out_ready;
  logic                busy;
  logic                err;

  logic [DW-1:0] q [NCHAN][$];
  logic [DW-1:0] acc_data[$];
  logic [CB-1:0] acc_chan[$];
  int            pop_cnt [NCHAN];
  int            passed = 0;
  int            total  = 0;

  fifo_drain_arb #(
    .NCHAN    (NCHAN),
    .CHANBITS (CB),
    .DATAWIDTH(DW),
    .BURSTBITS(BB)
  ) dut (
    .clk         (clk),
    .reset_l     (reset_l),
    .enable      (enable),
    .fifo_ne     (fifo_ne),
    .fifo_rd_data(fifo_rd_data),
    .fifo_unf    (fifo_unf),
    .fifo_re     (fifo_re),
    .out_data    (out_data),
    .out_chan    (out_chan),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] wd(int c, int k);
    return DW'((c << 8) | (k + 1));
  endfunction

  task automatic refresh();
    for (int c = 0; c < NCHAN; c++) begin
      fifo_ne[c] = (q[c].size() != 0);
      fifo_rd_data[c*DW +: DW] = (q[c].size() != 0) ? q[c][0] : '0;
    end
  endtask

  // One clock cycle: sample the pop and accept strobes before the edge, then apply them to the model.
  task automatic tick();
    logic [NCHAN-1:0] re_s;
    logic             acc;
    logic [DW-1:0]    d_s;
    logic [CB-1:0]    c_s;
    #2;
    re_s = fifo_re;
    acc  = out_valid && out_ready;
    d_s  = out_data;
    c_s  = out_chan;
    @(posedge clk);
    #1;
    if (acc) begin
      acc_data.push_back(d_s);
      acc_chan.push_back(c_s);
    end
    for (int c = 0; c < NCHAN; c++) begin
      if (re_s[c]) begin
        total++;
        if (q[c].size() == 0) $display("FAIL pop_empty: ch%0d popped while empty", c);
        else begin
          passed++;
          void'(q[c].pop_front());
          pop_cnt[c]++;
        end
      end
    end
    refresh();
    #1;
  endtask

  task automatic do_reset();
    reset_l   = 1'b0;
    enable    = 1'b1;
    out_ready = 1'b1;
    fifo_unf  = '0;
    for (int c = 0; c < NCHAN; c++) begin
      q[c].delete();
      pop_cnt[c] = 0;
    end
    acc_data.delete();
    acc_chan.delete();
    refresh();
    tick();
    tick();
    reset_l = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset_l      = 1'b0;
    enable       = 1'($urandom);
    out_ready    = 1'($urandom);
    fifo_ne      = NCHAN'($urandom);
    fifo_unf     = NCHAN'($urandom);
    fifo_rd_data = {$urandom, $urandom, $urandom};
    #7;
    fifo_ne  = NCHAN'($urandom);
    fifo_unf = NCHAN'($urandom);
    #7;
    total++;
    if ({out_valid, out_data, out_chan, busy, err, fifo_re} !== '0)
      $display("FAIL reset_outputs: got v=%b d=%0h c=%0d busy=%b err=%b re=%b want all 0",
               out_valid, out_data, out_chan, busy, err, fifo_re);
    else passed++;
    do_reset();
    for (int i = 0; i < 3; i++) tick();
    total++;
    if ({out_valid, out_data, out_chan, busy, err, fifo_re} !== '0)
      $display("FAIL reset_release_idle: got v=%b d=%0h c=%0d busy=%b err=%b re=%b want all 0",
               out_valid, out_data, out_chan, busy, err, fifo_re);
    else passed++;
  endtask

  task automatic test_single();
    do_reset();
    for (int k = 0; k < 3; k++) q[1].push_back(wd(1, k));
    refresh();
    tick();
    total++;
    if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy);
    else passed++;
    total++;
    if (fifo_re !== 4'b0010) $display("FAIL single_first_re: got %b want 0010", fifo_re);
    else passed++;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (out_valid !== 1'b1 || out_data !== wd(1, k))
        $display("FAIL single_word%0d: got v=%b d=%0h want v=1 d=%0h", k, out_valid, out_data,
                 wd(1, k));
      else passed++;
      total++;
      if (out_chan !== 2'd1) $display("FAIL single_chan%0d: got %0d want 1", k, out_chan);
      else passed++;
    end
    tick();
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL single_end: got busy=%b v=%b want 0 0", busy, out_valid);
    else passed++;
    total++;
    if (pop_cnt[1] !== 3) $display("FAIL single_re_cycles: got %0d want 3", pop_cnt[1]);
    else passed++;
  endtask

  task automatic test_fairness();
    int ticks;
    int busy_cycles;
    int ch;
    int k;
    do_reset();
    for (int c = 0; c < NCHAN; c++)
      for (int j = 0; j < 20; j++) q[c].push_back(wd(c, j));
    refresh();
    ticks       = 0;
    busy_cycles = 0;
    while (acc_data.size() < 80 && ticks < 200) begin
      tick();
      ticks++;
      if (busy) busy_cycles++;
    end
    total++;
    if (acc_data.size() != 80) $display("FAIL fair_count: got %0d words want 80", acc_data.size());
    else passed++;
    for (int i = 0; i < acc_data.size() && i < 80; i++) begin
      if (i < 64) begin
        ch = (i / 8) % 4;
        k  = (i / 32) * 8 + (i % 8);
      end else begin
        ch = (i - 64) / 4;
        k  = 16 + (i - 64) % 4;
      end
      total++;
      if (acc_chan[i] !== CB'(ch) || acc_data[i] !== wd(ch, k))
        $display("FAIL fair_word%0d: got ch%0d d=%0h want ch%0d d=%0h", i, acc_chan[i],
                 acc_data[i], ch, wd(ch, k));
      else passed++;
    end
    total++;
    if (busy_cycles != 84) $display("FAIL fair_busy_cycles: got %0d want 84", busy_cycles);
    else passed++;
    total++;
    if (ticks != 96) $display("FAIL fair_total_cycles: got %0d want 96", ticks);
    else passed++;
  endtask

  task automatic test_backpressure();
    int guard;
    do_reset();
    for (int j = 0; j < 8; j++) q[0].push_back(wd(0, j));
    refresh();
    guard = 0;
    while (!(out_valid && out_data == wd(0, 2)) && guard < 20) begin
      tick();
      guard++;
    end
    total++;
    if (guard >= 20) $display("FAIL bp_reach_word3: got timeout want word3 shown");
    else passed++;
    out_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (fifo_re !== 4'b0000 || out_valid !== 1'b1 || out_data !== wd(0, 2))
        $display("FAIL bp_hold%0d: got re=%b v=%b d=%0h want re=0000 v=1 d=%0h", i, fifo_re,
                 out_valid, out_data, wd(0, 2));
      else passed++;
      tick();
    end
    out_ready = 1'b1;
    guard = 0;
    while (acc_data.size() < 8 && guard < 40) begin
      tick();
      guard++;
    end
    total++;
    if (acc_data.size() != 8) $display("FAIL bp_count: got %0d want 8", acc_data.size());
    else passed++;
    for (int j = 0; j < acc_data.size() && j < 8; j++) begin
      total++;
      if (acc_data[j] !== wd(0, j))
        $display("FAIL bp_word%0d: got %0h want %0h", j, acc_data[j], wd(0, j));
      else passed++;
    end
  endtask

  task automatic test_err_enable();
    int guard;
    do_reset();
    total++;
    if (err !== 1'b0) $display("FAIL err_initial: got %b want 0", err);
    else passed++;
    fifo_unf = 4'b0100;
    tick();
    fifo_unf = '0;
    total++;
    if (err !== 1'b1) $display("FAIL err_rise: got %b want 1", err);
    else passed++;
    for (int i = 0; i < 3; i++) tick();
    total++;
    if (err !== 1'b1) $display("FAIL err_sticky: got %b want 1", err);
    else passed++;
    enable = 1'b0;
    for (int j = 0; j < 8; j++) q[3].push_back(wd(3, j));
    refresh();
    for (int i = 0; i < 4; i++) tick();
    total++;
    if (busy !== 1'b0 || fifo_re !== 4'b0000 || q[3].size() != 8)
      $display("FAIL enable_off_idle: got busy=%b re=%b left=%0d want 0 0000 8", busy, fifo_re,
               q[3].size());
    else passed++;
    enable = 1'b1;
    tick();
    total++;
    if (busy !== 1'b1) $display("FAIL enable_grant: got busy=%b want 1", busy);
    else passed++;
    tick();
    tick();
    enable = 1'b0;
    guard  = 0;
    while (acc_data.size() < 8 && guard < 30) begin
      tick();
      guard++;
    end
    total++;
    if (acc_data.size() != 8) $display("FAIL enable_burst_count: got %0d want 8", acc_data.size());
    else passed++;
    for (int j = 0; j < acc_data.size() && j < 8; j++) begin
      total++;
      if (acc_chan[j] !== 2'd3 || acc_data[j] !== wd(3, j))
        $display("FAIL enable_burst_word%0d: got ch%0d d=%0h want ch3 d=%0h", j, acc_chan[j],
                 acc_data[j], wd(3, j));
      else passed++;
    end
    total++;
    if (err !== 1'b1) $display("FAIL err_hold_end: got %b want 1", err);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int guard;
    do_reset();
    total++;
    if (err !== 1'b0) $display("FAIL err_cleared_by_reset: got %b want 0", err);
    else passed++;
    for (int j = 0; j < 8; j++) begin
      q[0].push_back(wd(0, j));
      q[1].push_back(wd(1, j));
    end
    refresh();
    guard = 0;
    while (pop_cnt[1] < 3 && guard < 40) begin
      tick();
      guard++;
    end
    total++;
    if (fifo_re !== 4'b0010) $display("FAIL mid_fourth_pop: got re=%b want 0010", fifo_re);
    else passed++;
    reset_l = 1'b0;
    #1;
    total++;
    if (fifo_re !== 4'b0000 || out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL mid_reset_now: got re=%b v=%b busy=%b want 0000 0 0", fifo_re, out_valid,
               busy);
    else passed++;
    acc_data.delete();
    acc_chan.delete();
    q[0].push_back(wd(0, 100));
    q[0].push_back(wd(0, 101));
    refresh();
    tick();
    tick();
    reset_l = 1'b1;
    guard = 0;
    while (acc_data.size() < 1 && guard < 20) begin
      tick();
      guard++;
    end
    total++;
    if (acc_data.size() < 1) $display("FAIL mid_restart: got no word want ch0 word");
    else if (acc_chan[0] !== 2'd0 || acc_data[0] !== wd(0, 100))
      $display("FAIL mid_restart: got ch%0d d=%0h want ch0 d=%0h", acc_chan[0], acc_data[0],
               wd(0, 100));
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_err_enable();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fifo_drain_arb.md
# fifo_drain_arb

Round-robin read-side arbiter that drains up to NCHAN `fifo_async_late` read ports into one registered output stream with valid/ready handshake. It sits in the read clock domain of the capture FIFOs, after the per-source async FIFOs and before the shared downstream consumer. Each grant drains a bounded burst from one channel. It also aggregates the FIFOs' underflow flags into a sticky error.

## Interface

Parameters:
- NCHAN, 4, number of FIFO channels (2..16).
- CHANBITS, 2, width of channel index; NCHAN <= 2^CHANBITS.
- DATAWIDTH, 18, FIFO/output word width.
- BURSTBITS, 3, log2 of max words per grant (BURST_LEN = 2^BURSTBITS).

Ports:
- clk  in  1  single clock, same as FIFO rd_clk.
- reset_l  in  1  asynchronous, active-low reset.
- enable  in  1  allow new grants; sampled only in IDLE.
- fifo_ne  in  NCHAN  per-channel FIFO not-empty.
- fifo_rd_data  in  NCHAN*DATAWIDTH  per-channel head word; channel i at [i*DATAWIDTH +: DATAWIDTH].
- fifo_unf  in  NCHAN  per-channel FIFO underflow flag.
- fifo_re  out  NCHAN  per-channel pop; combinational, at most one bit set.
- out_data  out  DATAWIDTH  registered output word.
- out_chan  out  CHANBITS  source channel of out_data.
- out_valid  out  1  out_data/out_chan valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- busy  out  1  state is BURST.
- err  out  1  sticky OR of fifo_unf.

## Operation

- Head word: fifo_rd_data[g] is valid whenever fifo_ne[g]=1. Asserting fifo_re[g] pops it in that cycle.
- States:
  - IDLE: if enable && |fifo_ne, latch grant g = first channel with ne set, searching from ptr upward with wrap modulo NCHAN. Clear count, go to BURST. Otherwise stay in IDLE.
  - BURST: can_load = !out_valid || out_ready.
    - fifo_re[g] = fifo_ne[g] && can_load.
    - On pop: out_data <= head word of g, out_chan <= g, out_valid <= 1, count <= count+1.
    - If a pop makes count reach BURST_LEN: go to IDLE, ptr <= g+1 (wrap).
    - If fifo_ne[g]=0: go to IDLE, ptr <= g+1, no pop.
- Output register: if out_valid && out_ready && no pop, out_valid <= 0. A pop and an accept in the same cycle keep out_valid=1 with the new word.
- fifo_re is 0 in IDLE and whenever can_load=0. The block never pops an empty FIFO.
- enable=0 in BURST has no effect; the current burst completes.
- err <= 1 when any fifo_unf bit is 1. It is cleared only by reset.
- count is BURSTBITS+1 bits wide. ptr is CHANBITS wide and wraps from NCHAN-1 to 0; values >= NCHAN never occur.

## Timing

- Reset (asynchronous, effective immediately):
  - state=IDLE, ptr=0, count=0.
  - out_valid=0, out_data=0, out_chan=0, err=0, busy=0.
  - fifo_re=0 combinationally.
- Reset asserted mid-burst aborts the burst. The word held in the output register is dropped.
- Latency with out_ready=1:
  - fifo_ne seen in IDLE at cycle t: BURST at t+1, first fifo_re at t+1, first out_valid at t+2.
  - One word per cycle thereafter.
- Arbitration cost: one IDLE cycle between bursts, so peak throughput is BURST_LEN/(BURST_LEN+1).
- Empty-terminated burst: the extra BURST cycle that sees ne=0, plus the IDLE cycle.
- Backpressure: while out_valid && !out_ready, fifo_re=0 and out_data/out_chan are held stable.
- err rises the cycle after fifo_unf is sampled high.

## Test plan

1. Reset: hold reset_l=0 with random inputs. Require all outputs 0 and fifo_re=0. Release reset with all FIFOs empty: outputs stay 0.
2. Single channel: NCHAN=4, BURSTBITS=3; ch1 holds 3 words A,B,C; out_ready=1. Require busy at t+1, then A,B,C on consecutive cycles from t+2 with out_chan=1, then IDLE. fifo_re[1] asserted exactly 3 cycles.
3. Fairness: all 4 channels hold 20 words each, out_ready=1. Require bursts ch0×8, ch1×8, ch2×8, ch3×8, ch0×8, ch1×8, ch2×8, ch3×8, then ch0×4, ch1×4, ch2×4, ch3×4. Each burst is separated by one IDLE cycle. Total 80 words, in per-channel order, none lost.
4. Backpressure: ch0 holds 8 words; drop out_ready for 5 cycles after the 3rd word. Require fifo_re=0 and out_data held at word 3 for those cycles, then words 4..8 in order.
5. Error and enable: pulse fifo_unf[2] for one cycle, then require err=1 until the next reset. Drop enable in IDLE with ch3 holding data: no grant. Drop enable in the middle of a ch3 burst: the burst still delivers all 8 words.
6. Reset mid-burst: assert reset_l=0 during the 4th pop of a burst. Require fifo_re=0 and out_valid=0 immediately. After release, arbitration restarts from ch0.
